// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle for alu_cmd_sequencer.
// slave: the sequencer; master: the command producer / result consumer.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_op, res_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_op, res_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO, issue/capture FSM and result handshake around a combinational 8-bit ALU.
// Optional macro ALU_DIVZERO_TRAP_EN: divide-by-zero captures report 8'hFF with res_err set.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [2:0]         alu_instruction,
    output logic [7:0]         alu_operand_a,
    output logic [7:0]         alu_operand_b,
    input  logic [7:0]         alu_result,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_STEP = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_STEP = AW'(1);
    localparam logic [CNT_W-1:0] OPS_STEP = CNT_W'(1);
    localparam logic [2:0] OP_DIV = 3'b010;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    cmd_t            fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            push, pop, empty;
    cmd_t            head;

    state_e          state_q, state_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic [2:0]      res_op_q, res_op_d;
    logic            res_err_q, res_err_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    assign bus.cmd_ready = (count_q != FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign empty         = (count_q == '0);
    assign head          = fifo_q[rd_ptr_q];

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_STEP;
        end else if (!push && pop) begin
            count_d = count_q - CNT_STEP;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    alu_op_d = head.op;
                    alu_a_d  = head.a;
                    alu_b_d  = head.b;
                    state_d  = StExec;
                end
            end
            StExec: begin
                res_op_d    = alu_op_q;
                res_valid_d = 1'b1;
                state_d     = StDone;
`ifdef ALU_DIVZERO_TRAP_EN
                if (alu_op_q == OP_DIV && alu_b_q == 8'h00) begin
                    res_data_d = 8'hFF;
                    res_err_d  = 1'b1;
                end else begin
                    res_data_d = alu_result;
                    res_err_d  = 1'b0;
                end
`else
                res_data_d = alu_result;
                res_err_d  = 1'b0;
`endif
            end
            StDone: begin
                // Result is held until the consumer takes it; only then may the next issue.
                if (res_valid_q && bus.res_ready) begin
                    op_count_d  = op_count_q + OPS_STEP;
                    res_valid_d = 1'b0;
                    if (!empty) begin
                        pop      = 1'b1;
                        alu_op_d = head.op;
                        alu_a_d  = head.a;
                        alu_b_d  = head.b;
                        state_d  = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_STEP;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_STEP;
            end
            count_q     <= count_d;
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_instruction = alu_op_q;
    assign alu_operand_a   = alu_a_q;
    assign alu_operand_b   = alu_b_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_op      = res_op_q;
    assign bus.res_err     = res_err_q;
    assign busy            = (state_q != StIdle) || !empty;
    assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; the bench itself plays the combinational ALU.
// A narrow op counter keeps the wrap-around reachable in a short run.
module tb_alu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [2:0]       alu_instruction;
    logic [7:0]       alu_operand_a;
    logic [7:0]       alu_operand_b;
    logic [7:0]       alu_result;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int               n_checks;
    int               n_fail;
    logic [CNT_W-1:0] exp_cnt;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .alu_instruction (alu_instruction),
        .alu_operand_a   (alu_operand_a),
        .alu_operand_b   (alu_operand_b),
        .alu_result      (alu_result),
        .busy            (busy),
        .op_count        (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_instruction)
            3'b000:  alu_result = alu_operand_a + alu_operand_b;
            3'b001:  alu_result = alu_operand_a - alu_operand_b;
            3'b010:  alu_result = (alu_operand_b == 8'h00) ? 8'h00 : alu_operand_a / alu_operand_b;
            3'b011:  alu_result = alu_operand_a * alu_operand_b;
            3'b100:  alu_result = alu_operand_a & alu_operand_b;
            3'b101:  alu_result = alu_operand_a | alu_operand_b;
            3'b110:  alu_result = ~alu_operand_a;
            default: alu_result = alu_operand_a ^ alu_operand_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) break;
            tick();
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_cmd timeout: cmd_ready=%b want 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_result(output logic [7:0] d, output logic [2:0] o, output logic e,
                              output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid) break;
            tick();
        end
        ok = (bus.res_valid === 1'b1);
        d  = bus.res_data;
        o  = bus.res_op;
        e  = bus.res_err;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready);
        end
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset res_valid: got %b want 0", bus.res_valid);
        end
        n_checks++;
        if ({bus.res_data, bus.res_op, bus.res_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset res_fields: got %h/%h/%b want 0", bus.res_data, bus.res_op,
                     bus.res_err);
        end
        n_checks++;
        if ({alu_instruction, alu_operand_a, alu_operand_b} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset alu_regs: got %h/%h/%h want 0", alu_instruction, alu_operand_a,
                     alu_operand_b);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset busy: got %b want 0", busy);
        end
        n_checks++;
        if (op_count !== '0) begin
            n_fail++; $display("FAIL reset op_count: got %h want 0", op_count);
        end
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_single_add();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 8'h30;
        bus.cmd_b     = 8'h12;
        tick();  // edge 0: accepted
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL add edge0: res_valid=%b busy=%b want 0/1", bus.res_valid, busy);
        end
        tick();  // edge 1: issued
        n_checks++;
        if ({alu_instruction, alu_operand_a, alu_operand_b} !== {3'b000, 8'h30, 8'h12} ||
            bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add issue: got %h/%h/%h rv=%b want 0/30/12 rv=0", alu_instruction,
                     alu_operand_a, alu_operand_b, bus.res_valid);
        end
        tick();  // edge 2: captured
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h42 || bus.res_op !== 3'b000 ||
            bus.res_err !== 1'b0) begin
            n_fail++;
            $display("FAIL add result: rv=%b data=%h op=%h err=%b want 1/42/0/0", bus.res_valid,
                     bus.res_data, bus.res_op, bus.res_err);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (op_count !== exp_cnt || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add handoff: op_count=%h rv=%b busy=%b want %h/0/0", op_count,
                     bus.res_valid, busy, exp_cnt);
        end
    endtask

    task automatic test_wrap_cases();
        logic [2:0] ops [5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
        logic [7:0] as  [5] = '{8'h05, 8'h20, 8'hC8, 8'h0F, 8'h5A};
        logic [7:0] bs  [5] = '{8'h07, 8'h10, 8'h07, 8'h00, 8'h5A};
        logic [7:0] exp [5] = '{8'hFE, 8'h00, 8'h1C, 8'hF0, 8'h00};
        logic [7:0] d;
        logic [2:0] o;
        logic       e;
        bit         ok;
        for (int i = 0; i < 5; i++) begin
            send_cmd(ops[i], as[i], bs[i]);
            get_result(d, o, e, ok);
            exp_cnt++;
            n_checks++;
            if (!ok || d !== exp[i] || o !== ops[i] || e !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_case %0d: ok=%b data=%h op=%h err=%b want %h/%h/0", i, ok, d,
                         o, e, exp[i], ops[i]);
            end
            n_checks++;
            if (op_count !== exp_cnt) begin
                n_fail++; $display("FAIL wrap_case op_count: got %h want %h", op_count, exp_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] ops [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b111, 3'b000};
        logic [7:0] as  [6] = '{8'h01, 8'h10, 8'hF0, 8'h0F, 8'hFF, 8'h80};
        logic [7:0] bs  [6] = '{8'h01, 8'h01, 8'h3C, 8'h30, 8'h0F, 8'h80};
        logic [7:0] exp [6] = '{8'h02, 8'h0F, 8'h30, 8'h3F, 8'hF0, 8'h00};
        int idx;
        int last;
        logic push_now;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_cmd(ops[i], as[i], bs[i]);
        n_checks++;
        if (bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== exp[0]) begin
            n_fail++;
            $display("FAIL bp_full: cmd_ready=%b rv=%b data=%h want 0/1/%h", bus.cmd_ready,
                     bus.res_valid, bus.res_data, exp[0]);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = ops[5];
        bus.cmd_a     = as[5];
        bus.cmd_b     = bs[5];
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.cmd_ready !== 1'b0 || bus.res_data !== exp[0] || bus.res_op !== ops[0]) begin
            n_fail++;
            $display("FAIL bp_hold: cmd_ready=%b data=%h op=%h want 0/%h/%h", bus.cmd_ready,
                     bus.res_data, bus.res_op, exp[0], ops[0]);
        end
        bus.res_ready = 1'b1;
        idx  = 0;
        last = 0;
        for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
            push_now = bus.cmd_valid && bus.cmd_ready;
            if (bus.res_valid) begin
                n_checks++;
                if (bus.res_data !== exp[idx] || bus.res_op !== ops[idx]) begin
                    n_fail++;
                    $display("FAIL bp_drain %0d: data=%h op=%h want %h/%h", idx, bus.res_data,
                             bus.res_op, exp[idx], ops[idx]);
                end
                if (idx > 0) begin
                    n_checks++;
                    if (cyc - last != 2) begin
                        n_fail++;
                        $display("FAIL bp_rate %0d: gap %0d cycles want 2", idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
            end
            tick();
            if (push_now) bus.cmd_valid = 1'b0;
        end
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_cnt = exp_cnt + CNT_W'(6);
        n_checks++;
        if (idx != 6 || op_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL bp_done: results=%0d op_count=%h want 6/%h", idx, op_count, exp_cnt);
        end
        n_checks++;
        if (alu_operand_a !== as[5] || alu_operand_b !== bs[5] || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_alu_hold: a=%h b=%h busy=%b want %h/%h/0", alu_operand_a,
                     alu_operand_b, busy, as[5], bs[5]);
        end
    endtask

    task automatic test_divzero();
        logic [7:0] d;
        logic [2:0] o;
        logic       e;
        bit         ok;
        logic [7:0] exp_d;
        logic       exp_e;
`ifdef ALU_DIVZERO_TRAP_EN
        exp_d = 8'hFF;
        exp_e = 1'b1;
`else
        exp_d = 8'h00;  // whatever the ALU produces for x/0
        exp_e = 1'b0;
`endif
        send_cmd(3'b010, 8'h09, 8'h00);
        get_result(d, o, e, ok);
        exp_cnt++;
        n_checks++;
        if (!ok || d !== exp_d || o !== 3'b010 || e !== exp_e) begin
            n_fail++;
            $display("FAIL divzero: ok=%b data=%h op=%h err=%b want %h/2/%b", ok, d, o, e, exp_d,
                     exp_e);
        end
        n_checks++;
        if (op_count !== exp_cnt) begin
            n_fail++; $display("FAIL divzero op_count: got %h want %h", op_count, exp_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int stale;
        bus.res_ready = 1'b0;
        send_cmd(3'b000, 8'h01, 8'h02);
        send_cmd(3'b000, 8'h03, 8'h04);
        send_cmd(3'b000, 8'h05, 8'h06);
        send_cmd(3'b000, 8'h07, 8'h08);
        bus.res_ready = 1'b1;
        tick();  // hand off first result, second enters EXEC with two queued
        bus.res_ready = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || alu_operand_a !== 8'h03) begin
            n_fail++;
            $display("FAIL midop_exec: rv=%b a=%h want 0/03", bus.res_valid, alu_operand_a);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            op_count !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: rv=%b busy=%b cmd_ready=%b op_count=%h want 0/0/1/0",
                     bus.res_valid, busy, bus.cmd_ready, op_count);
        end
        rst = 1'b0;
        exp_cnt = '0;
        bus.res_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.res_valid || busy) stale++;
            tick();
        end
        bus.res_ready = 1'b0;
        n_checks++;
        if (stale != 0 || op_count !== '0) begin
            n_fail++;
            $display("FAIL midop_stale: active cycles=%0d op_count=%h want 0/0", stale, op_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5] = '{3'b001, 3'b101, 3'b100, 3'b111, 3'b000};
        logic [7:0] exp [5] = '{8'h40, 8'h03, 8'h0F, 8'h3C, 8'h80};
        logic [7:0] d;
        logic [2:0] o;
        logic       e;
        bit         ok;
        bus.res_ready = 1'b0;
        send_cmd(3'b000, 8'h11, 8'h22);
        send_cmd(3'b001, 8'h50, 8'h10);
        send_cmd(3'b101, 8'h01, 8'h02);
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h33) begin
            n_fail++;
            $display("FAIL b2b_first: rv=%b data=%h want 1/33", bus.res_valid, bus.res_data);
        end
        // Push and pop on the same edge with two entries queued.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b100;
        bus.cmd_a     = 8'hFF;
        bus.cmd_b     = 8'h0F;
        bus.res_ready = 1'b1;
        tick();
        exp_cnt++;
        bus.res_ready = 1'b0;
        bus.cmd_op    = 3'b111;
        bus.cmd_a     = 8'h33;
        bus.cmd_b     = 8'h0F;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_count2: cmd_ready=%b want 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_op = 3'b000;
        bus.cmd_a  = 8'h7F;
        bus.cmd_b  = 8'h01;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_count3: cmd_ready=%b want 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count4: cmd_ready=%b want 0", bus.cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            get_result(d, o, e, ok);
            exp_cnt++;
            n_checks++;
            if (!ok || d !== exp[i] || o !== ops[i] || op_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL b2b_order %0d: ok=%b data=%h op=%h cnt=%h want %h/%h/%h", i, ok, d,
                         o, op_count, exp[i], ops[i], exp_cnt);
            end
        end
        for (int i = 0; i < 20 && exp_cnt != '1; i++) begin
            send_cmd(3'b000, 8'h00, 8'h01);
            get_result(d, o, e, ok);
            exp_cnt++;
        end
        n_checks++;
        if (op_count !== '1) begin
            n_fail++; $display("FAIL wrap_top: op_count=%h want all ones", op_count);
        end
        send_cmd(3'b000, 8'h02, 8'h03);
        get_result(d, o, e, ok);
        n_checks++;
        if (!ok || d !== 8'h05 || op_count !== '0) begin
            n_fail++;
            $display("FAIL wrap_zero: ok=%b data=%h op_count=%h want 05/0", ok, d, op_count);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_cnt       = '0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_wrap_cases();
        test_backpressure();
        test_divzero();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
